egress_port_arbiter: RTL and testbench



---
 rtl/egress_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_egress_port_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_port_arbiter.sv
// Locks one egress AXI-stream port to a tdest-matching requester (round robin) until tlast or a stall watchdog abort.
// Grant 1 cycle after request; datapath is combinational; egress_tready passes only to the owner, and backpressure never counts as a stall.
module egress_port_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int DEST_WIDTH      = 2,
    parameter int PORT_ID         = 0,
    parameter int STALL_CTR_WIDTH = 4,
    parameter int STAT_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_tvalid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_tdata,
    input  logic [NUM_REQ-1:0]               req_tlast,
    input  logic [NUM_REQ*DEST_WIDTH-1:0]    req_tdest,
    output logic [NUM_REQ-1:0]               req_tready,
    output logic                             egress_tvalid,
    output logic [DATA_WIDTH-1:0]            egress_tdata,
    output logic                             egress_tlast,
    input  logic                             egress_tready,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             abort,
    output logic [STAT_WIDTH-1:0]            frame_count,
    output logic [STAT_WIDTH-1:0]            abort_count
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [IW-1:0]            owner_q, owner_d;
    logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [STALL_CTR_WIDTH:0] stall_q, stall_d;
    logic                     abort_q, abort_d;
    logic [STAT_WIDTH-1:0]    frame_q, frame_d;
    logic [STAT_WIDTH-1:0]    abcnt_q, abcnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [IW:0]        scan;
    logic [IW-1:0]      owner_nxt;
    logic               locked, own_tvalid, own_tlast, hs;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_tvalid[i] &
                          (req_tdest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(PORT_ID));
        end
    end

    // First eligible index at or above rr_ptr, wrapping; scan is one bit wider so the wrap is exact for any NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan >= (IW+1)'(NUM_REQ)) begin
                scan = scan - (IW+1)'(NUM_REQ);
            end
            if (!pick_vld && eligible[scan[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[IW-1:0];
            end
        end
    end

    assign owner_nxt  = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
    assign locked     = (state_q == LOCKED);
    assign own_tvalid = locked & req_tvalid[owner_q];
    assign own_tlast  = locked & req_tlast[owner_q];
    assign hs         = own_tvalid & egress_tready;

    assign grant         = locked ? (NUM_REQ'(1) << owner_q) : '0;
    assign req_tready    = grant & {NUM_REQ{egress_tready}};
    assign egress_tvalid = own_tvalid;
    assign egress_tlast  = own_tlast;
    assign egress_tdata  = locked ? req_tdata[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign abort         = abort_q;
    assign frame_count   = frame_q;
    assign abort_count   = abcnt_q;

    // The watchdog acts on the registered overflow bit, so a tlast beat arriving in that same cycle still completes the frame.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;
        abort_d  = 1'b0;
        frame_d  = frame_q;
        abcnt_d  = abcnt_q;
        if (state_q == IDLE) begin
            stall_d = '0;
            if (pick_vld) begin
                state_d = LOCKED;
                owner_d = pick_idx;
            end
        end else begin
            if (hs) begin
                stall_d = '0;
            end else if (!own_tvalid) begin
                stall_d = stall_q + 1'b1;
            end
            if (hs && own_tlast) begin
                state_d  = IDLE;
                rr_ptr_d = owner_nxt;
                frame_d  = frame_q + 1'b1;
            end else if (stall_q[STALL_CTR_WIDTH]) begin
                state_d  = IDLE;
                rr_ptr_d = owner_nxt;
                abort_d  = 1'b1;
                abcnt_d  = abcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
            abort_q  <= 1'b0;
            frame_q  <= '0;
            abcnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
            abort_q  <= abort_d;
            frame_q  <= frame_d;
            abcnt_q  <= abcnt_d;
        end
    end

endmodule

// File: tb/tb_egress_port_arbiter.sv
// Bench for egress_port_arbiter: directed scenarios with fixed expectations, then random traffic against a behavioural model.
module tb_egress_port_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int SW  = 2;
    localparam int PID = 0;
    localparam int STW = 16;
    localparam int STALL_LIMIT = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_tvalid;
    logic [N*DW-1:0] req_tdata;
    logic [N-1:0]    req_tlast;
    logic [N*SW-1:0] req_tdest;
    logic [N-1:0]    req_tready;
    logic            egress_tvalid;
    logic [DW-1:0]   egress_tdata;
    logic            egress_tlast;
    logic            egress_tready;
    logic [N-1:0]    grant;
    logic            abort;
    logic [STW-1:0]  frame_count;
    logic [STW-1:0]  abort_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: owner index (-1 when free), next priority index, consecutive idle cycles of the owner.
    int             m_owner;
    int             m_ptr;
    int             m_stall;
    logic           m_abort;
    logic [STW-1:0] m_frames;
    logic [STW-1:0] m_aborts;

    egress_port_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .DEST_WIDTH(SW), .PORT_ID(PID),
        .STALL_CTR_WIDTH(4), .STAT_WIDTH(STW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tlast(req_tlast),
        .req_tdest(req_tdest), .req_tready(req_tready),
        .egress_tvalid(egress_tvalid), .egress_tdata(egress_tdata),
        .egress_tlast(egress_tlast), .egress_tready(egress_tready),
        .grant(grant), .abort(abort),
        .frame_count(frame_count), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    function automatic logic elig(int i);
        logic [SW-1:0] d;
        d = req_tdest[i*SW +: SW];
        return req_tvalid[i] && (d == SW'(PID));
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_stall = 0; m_abort = 1'b0;
        m_frames = '0; m_aborts = '0;
    endtask

    task automatic model_edge();
        logic v;
        m_abort = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && elig((m_ptr + k) % N)) begin
                    m_owner = (m_ptr + k) % N;
                    m_stall = 0;
                end
            end
        end else begin
            v = req_tvalid[m_owner];
            if (v && egress_tready && req_tlast[m_owner]) begin
                m_frames = m_frames + 1'b1;
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_stall >= STALL_LIMIT) begin
                m_aborts = m_aborts + 1'b1;
                m_abort = 1'b1;
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else if (v && egress_tready) begin
                m_stall = 0;
            end else if (!v) begin
                m_stall = m_stall + 1;
            end
        end
    endtask

    task automatic tick();
        if (reset_n) model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_tvalid = '0; req_tdata = '0; req_tlast = '0; req_tdest = '0;
        egress_tready = 1'b1;
    endtask

    task automatic set_req(int i, logic v, logic [DW-1:0] d, logic l, logic [SW-1:0] dst);
        req_tvalid[i] = v;
        req_tdata[i*DW +: DW] = d;
        req_tlast[i] = l;
        req_tdest[i*SW +: SW] = dst;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        req_tvalid = '1;
        repeat (2) @(negedge clk);
        model_reset();
        n_vec++;
        if ({grant, req_tready, egress_tvalid, abort} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b want all 0", grant, req_tready, egress_tvalid, abort);
        end
        n_vec++;
        if ({frame_count, abort_count} !== '0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_count, abort_count);
        end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 16'h00A1, 1'b0, 2'd0);
        #1;
        n_vec++;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL single_idle_grant: got %b want 0000", grant); end
        tick();
        #1;
        n_vec++;
        if ({grant, req_tready, egress_tdata} !== {4'b0010, 4'b0010, 16'h00A1}) begin
            n_err++;
            $display("FAIL single_beat1: got %b %b %h want 0010 0010 00a1", grant, req_tready, egress_tdata);
        end
        tick();
        set_req(1, 1'b1, 16'h00A2, 1'b0, 2'd0);
        #1;
        n_vec++;
        if ({egress_tvalid, egress_tlast, egress_tdata} !== {1'b1, 1'b0, 16'h00A2}) begin
            n_err++;
            $display("FAIL single_beat2: got v%b l%b %h want v1 l0 00a2", egress_tvalid, egress_tlast, egress_tdata);
        end
        tick();
        set_req(1, 1'b1, 16'h00A3, 1'b1, 2'd0);
        #1;
        n_vec++;
        if ({egress_tvalid, egress_tlast, egress_tdata} !== {1'b1, 1'b1, 16'h00A3}) begin
            n_err++;
            $display("FAIL single_beat3: got v%b l%b %h want v1 l1 00a3", egress_tvalid, egress_tlast, egress_tdata);
        end
        tick();
        // Requesters 0..2 now all compete; rr_ptr should have moved to 2.
        req_tvalid = 4'b0111; req_tlast = 4'b1111; req_tdest = '0;
        #1;
        n_vec++;
        if ({grant, frame_count} !== {4'b0000, 16'd1}) begin
            n_err++;
            $display("FAIL single_release: got grant %b frames %0d want 0000 1", grant, frame_count);
        end
        tick();
        #1;
        n_vec++;
        if (grant !== 4'b0100) begin n_err++; $display("FAIL single_rr_ptr: got %b want 0100", grant); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        reset_n = 1'b0;
        clear_inputs();
        req_tvalid = '1; req_tlast = '1;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_g = (k % 2 == 1) ? (N'(1) << ((k / 2) % N)) : '0;
            n_vec++;
            if (grant !== exp_g) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got %b want %b", k, grant, exp_g);
            end
            tick();
        end
        #1;
        n_vec++;
        if (frame_count !== 16'd5) begin n_err++; $display("FAIL rr_frames: got %0d want 5", frame_count); end
        clear_inputs();
        tick();
    endtask

    task automatic test_dest_filter();
        clear_inputs();
        set_req(2, 1'b1, 16'h2222, 1'b1, 2'd1);
        for (int k = 0; k < 20; k++) begin
            #1;
            n_vec++;
            if ({grant, req_tready, egress_tvalid} !== '0) begin
                n_err++;
                $display("FAIL dest_filter[%0d]: got %b %b %b want 0", k, grant, req_tready, egress_tvalid);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        egress_tready = 1'b0;
        set_req(0, 1'b1, 16'h55AA, 1'b0, 2'd0);
        tick();
        for (int k = 0; k < 30; k++) begin
            if (k == 10) req_tdest[0 +: SW] = 2'd2;
            #1;
            n_vec++;
            if ({grant, abort, egress_tvalid, req_tready, egress_tdata} !== {4'b0001, 1'b0, 1'b1, 4'b0000, 16'h55AA}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got g%b a%b v%b r%b %h want g0001 a0 v1 r0000 55aa",
                         k, grant, abort, egress_tvalid, req_tready, egress_tdata);
            end
            tick();
        end
        egress_tready = 1'b1;
        req_tlast[0] = 1'b1;
        #1;
        n_vec++;
        if (req_tready !== 4'b0001) begin n_err++; $display("FAIL bp_ready: got %b want 0001", req_tready); end
        tick();
        clear_inputs();
        #1;
        n_vec++;
        if ({grant, abort_count} !== {4'b0000, 16'd0}) begin
            n_err++;
            $display("FAIL bp_release: got grant %b aborts %0d want 0000 0", grant, abort_count);
        end
        tick();
    endtask

    task automatic test_watchdog();
        clear_inputs();
        set_req(3, 1'b1, 16'h0033, 1'b0, 2'd0);
        tick();
        #1;
        n_vec++;
        if (grant !== 4'b1000) begin n_err++; $display("FAIL wd_grant: got %b want 1000", grant); end
        tick();
        req_tvalid[3] = 1'b0;
        for (int k = 0; k < STALL_LIMIT + 1; k++) begin
            #1;
            n_vec++;
            if ({grant, abort} !== {4'b1000, 1'b0}) begin
                n_err++;
                $display("FAIL wd_stall[%0d]: got g%b a%b want g1000 a0", k, grant, abort);
            end
            tick();
        end
        req_tvalid = 4'b1010; req_tlast = 4'b1111; req_tdest = '0;
        #1;
        n_vec++;
        if ({abort, grant, abort_count} !== {1'b1, 4'b0000, 16'd1}) begin
            n_err++;
            $display("FAIL wd_abort: got a%b g%b cnt %0d want a1 g0000 cnt 1", abort, grant, abort_count);
        end
        tick();
        #1;
        n_vec++;
        if ({grant, abort} !== {4'b0010, 1'b0}) begin
            n_err++;
            $display("FAIL wd_next_winner: got g%b a%b want g0010 a0", grant, abort);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_tie();
        clear_inputs();
        set_req(0, 1'b1, 16'h0777, 1'b0, 2'd0);
        tick();
        tick();
        req_tvalid[0] = 1'b0;
        repeat (STALL_LIMIT) tick();
        set_req(0, 1'b1, 16'h0778, 1'b1, 2'd0);
        #1;
        n_vec++;
        if ({grant, egress_tlast} !== {4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL tie_lock_held: got g%b l%b want g0001 l1", grant, egress_tlast);
        end
        tick();
        clear_inputs();
        #1;
        n_vec++;
        if ({abort, grant, frame_count, abort_count} !== {1'b0, 4'b0000, 16'd8, 16'd1}) begin
            n_err++;
            $display("FAIL tie_result: got a%b g%b frames %0d aborts %0d want a0 g0000 8 1",
                     abort, grant, frame_count, abort_count);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        clear_inputs();
        set_req(1, 1'b1, 16'h0BEE, 1'b0, 2'd0);
        tick();
        #1;
        n_vec++;
        if (egress_tvalid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got v%b want v1", egress_tvalid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({grant, egress_tvalid, req_tready, frame_count} !== '0) begin
            n_err++;
            $display("FAIL midrst_async: got g%b v%b r%b frames %0d want all 0", grant, egress_tvalid, req_tready, frame_count);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [N-1:0]  eg, er;
        logic          ev, el;
        logic [DW-1:0] ed;
        logic          busy;
        clear_inputs();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            busy = ((c / 150) % 2) == 0;
            for (int i = 0; i < N; i++) begin
                req_tvalid[i] = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
                req_tdest[i*SW +: SW] = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 3)) : SW'(PID);
                req_tdata[i*DW +: DW] = DW'($urandom);
                req_tlast[i] = ($urandom_range(0, 3) == 0);
            end
            egress_tready = ($urandom_range(0, 3) != 0);
            #1;
            eg = '0; ev = 1'b0; el = 1'b0; ed = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ev = req_tvalid[m_owner];
                el = req_tlast[m_owner];
                ed = req_tdata[m_owner*DW +: DW];
            end
            er = egress_tready ? eg : '0;
            n_vec++;
            if ({grant, req_tready, egress_tvalid, egress_tlast, abort} !== {eg, er, ev, el, m_abort}) begin
                n_err++;
                $display("FAIL rnd_ctrl[%0d]: got g%b r%b v%b l%b a%b want g%b r%b v%b l%b a%b", c,
                         grant, req_tready, egress_tvalid, egress_tlast, abort, eg, er, ev, el, m_abort);
            end
            n_vec++;
            if (egress_tdata !== ed) begin
                n_err++;
                $display("FAIL rnd_data[%0d]: got %h want %h", c, egress_tdata, ed);
            end
            n_vec++;
            if ({frame_count, abort_count} !== {m_frames, m_aborts}) begin
                n_err++;
                $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", c, frame_count, abort_count, m_frames, m_aborts);
            end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_dest_filter();
        test_backpressure();
        test_watchdog();
        test_tie();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
